// File: rtl/sync_debounce_multi.sv
// sync_debounce_multi
//
// Multi-channel input conditioner. Each of WIDTH asynchronous inputs passes
// through a STAGES-deep synchroniser chain. A per-channel counter then
// debounces it: the debounced level flips only after the synchronised value
// has differed from it on DEB_CNT consecutive clock edges. Registered
// one-cycle rise/fall pulses are asserted in the cycle the level changes.
//
// Optional feature (macro SYNC_STICKY_EVT_EN): adds per-channel sticky
// event flags that latch any rise/fall pulse and are cleared by evt_clr.
// If a set and a clear coincide, the set wins.
//
// Ports:
//   clk         input   1      system clock, all logic on posedge
//   rst_n       input   1      synchronous active-low reset
//   in          input   WIDTH  asynchronous raw inputs
//   input_sync  output  WIDTH  synchroniser outputs (not debounced)
//   level       output  WIDTH  debounced level per channel
//   rise        output  WIDTH  one-cycle pulse on level 0->1
//   fall        output  WIDTH  one-cycle pulse on level 1->0
//   evt_clr     input   WIDTH  sticky event clear   (SYNC_STICKY_EVT_EN only)
//   evt         output  WIDTH  sticky event flags   (SYNC_STICKY_EVT_EN only)

module sync_debounce_multi #(
    parameter int WIDTH   = 4,
    parameter int STAGES  = 2,
    parameter int DEB_CNT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] input_sync,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef SYNC_STICKY_EVT_EN
    ,
    input  logic [WIDTH-1:0] evt_clr,
    output logic [WIDTH-1:0] evt
`endif
);

    localparam int CW_RAW = $clog2(DEB_CNT + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

    // Counter value on which the DEB_CNT-th differing edge is being seen.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [WIDTH-1:0] sync_chain [STAGES];
    logic [CW-1:0]    cnt        [WIDTH];

    // Synchroniser chain: stage 0 samples the raw asynchronous inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_chain[k] <= '0;
            end
        end else begin
            sync_chain[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                sync_chain[k] <= sync_chain[k-1];
            end
        end
    end

    assign input_sync = sync_chain[STAGES-1];

    // Debounce: any edge where the synchronised value agrees with the level
    // restarts the count, so glitches shorter than DEB_CNT cycles vanish.
    // The counter is cleared on the flip itself and so never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
            rise  <= '0;
            fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (input_sync[i] == level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    level[i] <= input_sync[i];
                    rise[i]  <= input_sync[i];
                    fall[i]  <= ~input_sync[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef SYNC_STICKY_EVT_EN
    // Sticky event flags: the set term is applied after the clear so that a
    // pulse coinciding with a clear still leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt <= '0;
        end else begin
            evt <= (evt & ~evt_clr) | rise | fall;
        end
    end
`endif

endmodule

// File: tb/tb_sync_debounce_multi.sv
module tb_sync_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in;
    logic [3:0] input_sync;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
`ifdef SYNC_STICKY_EVT_EN
    logic [3:0] evt_clr;
    logic [3:0] evt;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #30 clk = ~clk;

    sync_debounce_multi #(
        .WIDTH  (4),
        .STAGES (2),
        .DEB_CNT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .input_sync(input_sync),
        .level     (level),
        .rise      (rise),
        .fall      (fall)
`ifdef SYNC_STICKY_EVT_EN
        ,
        .evt_clr   (evt_clr),
        .evt       (evt)
`endif
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] in;
        logic [3:0] sync;
        logic [3:0] level;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vec [24];

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One posedge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        string tag;

        // Expected state after each posedge (inputs applied before it).
        // Reset with in=F, release, level/rise at the 6th edge after release.
        vec[0]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[1]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[4]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vec[5]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vec[6]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vec[7]  = '{1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
        vec[8]  = '{1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        vec[9]  = '{1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
        // Simultaneous fall on all channels.
        vec[10] = '{1'b1, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0};
        vec[11] = '{1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        vec[12] = '{1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        vec[13] = '{1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        vec[14] = '{1'b1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
        vec[15] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        vec[16] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        // Clean rise on channel 0 from idle.
        vec[17] = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};
        vec[18] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        vec[19] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        vec[20] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        vec[21] = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
        vec[22] = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0};
        vec[23] = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0};

        rst_n = 1'b0;
        in    = 4'hF;
`ifdef SYNC_STICKY_EVT_EN
        evt_clr = 4'h0;
`endif

        for (int v = 0; v < 24; v++) begin
            rst_n = vec[v].rst_n;
            in    = vec[v].in;
            tick();
            tag = $sformatf("v%0d", v);
            chk({tag, " input_sync"}, input_sync, vec[v].sync);
            chk({tag, " level"},      level,      vec[v].level);
            chk({tag, " rise"},       rise,       vec[v].rise);
            chk({tag, " fall"},       fall,       vec[v].fall);
        end

        // Glitch on channel 1: three cycles high reaches count DEB_CNT-1 only.
        seen = 1'b0;
        in = 4'h3;
        for (int t = 0; t < 12; t++) begin
            if (t == 3) in = 4'h1;
            tick();
            if (input_sync[1]) seen = 1'b1;
            chk("glitch level", level, 4'h1);
            chk("glitch rise",  rise,  4'h0);
            chk("glitch fall",  fall,  4'h0);
        end
        chk("glitch sync pulsed", {3'b0, seen}, 4'h1);

        // Chatter on channel 2, 160 ns phases, offset from the clock edges.
        fork
            begin
                in[2] = 1'b1;
                for (int k = 0; k < 13; k++) begin
                    #160;
                    in[2] = ~in[2];
                end
            end
            begin
                for (int t = 0; t < 40; t++) begin
                    tick();
                    chk("chatter level", level, 4'h1);
                    chk("chatter rise",  rise,  4'h0);
                    chk("chatter fall",  fall,  4'h0);
                end
            end
        join
        chk("chatter in settled", in, 4'h1);

        // Reset in the middle of a count on channel 3.
        in = 4'h9;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("pre-reset level", level, 4'h1);
            chk("pre-reset rise",  rise,  4'h0);
        end
        rst_n = 1'b0;
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("mid reset level", level, 4'h0);
            chk("mid reset rise",  rise,  4'h0);
            chk("mid reset fall",  fall,  4'h0);
            chk("mid reset sync",  input_sync, 4'h0);
        end
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk($sformatf("rel r%0d level", t), level, (t >= 6) ? 4'h9 : 4'h0);
            chk($sformatf("rel r%0d rise",  t), rise,  (t == 6) ? 4'h9 : 4'h0);
`ifdef SYNC_STICKY_EVT_EN
            chk($sformatf("rel r%0d evt",   t), evt,   (t == 7) ? 4'h9 : 4'h0);
`endif
        end

`ifdef SYNC_STICKY_EVT_EN
        // Flags hold until cleared.
        tick(); chk("evt hold 1", evt, 4'h9);
        tick(); chk("evt hold 2", evt, 4'h9);
        evt_clr = 4'h8;
        tick(); chk("evt clr3", evt, 4'h1);
        evt_clr = 4'h0;

        // Channel 3 falls; clear lands on the same edge as the new event.
        in = 4'h1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            chk($sformatf("f%0d level", t), level, (t == 6) ? 4'h1 : 4'h9);
            chk($sformatf("f%0d fall",  t), fall,  (t == 6) ? 4'h8 : 4'h0);
        end
        evt_clr = 4'h8;
        tick();
        chk("set beats clear", evt, 4'h9);
        chk("fall one cycle",  fall, 4'h0);
        tick();
        chk("evt clr after",   evt, 4'h1);
        evt_clr = 4'h0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
